operand_feeder: RTL and testbench
=================================

Name: operand_feeder

Overview:
- Upstream stage of the serial adder top level. Accepts parallel operand words A, B and carry-in over a valid/ready handshake.
- Buffers accepted words in a small FIFO and shifts them out bit-serially, LSB first, on two lanes with a shared valid.
- Holds carry-in stable for the duration of each word.
- Lets the bench or a host drive the adder with whole words instead of bit streams.

Parameters:
- DATA_WIDTH, 16, operand width and number of serial bits per word.
- FIFO_DEPTH, 4, number of buffered operand words; power of two, 2 or more.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-low reset.
- i_en  input  1  global enable; when low, all state is frozen.
- iv_a  input  DATA_WIDTH  operand A word.
- iv_b  input  DATA_WIDTH  operand B word.
- i_cin  input  1  carry-in for this word pair.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  feeder can accept a word.
- i_ready  input  1  downstream (adder) ready for a serial bit.
- o_din_a  output  1  serial bit of A.
- o_din_b  output  1  serial bit of B.
- o_cin  output  1  carry-in of the word currently shifting.
- o_valid  output  1  o_din_a/o_din_b valid.

Behaviour:
- Reset: i_rst=0 sampled at an edge clears the FIFO (empty) and the bit counter, and sets state IDLE. Outputs after reset: o_valid=0, o_din_a=0, o_din_b=0, o_cin=0, o_ready=0 while i_rst=0, then 1 once released.
- Reset mid-word: the word being shifted and all buffered words are discarded. No partial word is resumed.
- Word accept: push occurs at an edge with i_valid & o_ready & i_en=1.
  - o_ready = i_en & !full & i_rst, combinational from registered FIFO count.
  - No pass-through: when the FIFO is full, o_ready=0 even if a pop happens that cycle.
- Bit transfer: occurs at an edge with o_valid & i_ready & i_en=1.
  - o_din_a/o_din_b carry bit [k] of the current word, k = 0 … DATA_WIDTH-1.
  - o_valid, o_din_* and o_cin remain stable while i_ready=0.
- FSM, two states:
  - IDLE: o_valid=0. If FIFO is non-empty and i_en=1, pop the head into the A/B shift registers and cin register, set k=0, go to SHIFT.
  - SHIFT: o_valid=1. On each transfer, shift both registers right and increment k.
    - On the transfer of k=DATA_WIDTH-1 with FIFO non-empty: pop the next word in the same edge and stay in SHIFT. This gives back-to-back words with no bubble.
    - On that transfer with FIFO empty: go to IDLE.
- Latency: a word pushed into an empty FIFO at edge E0 is loaded at E1; o_valid=1 and bit 0 are visible after E1.
- Simultaneous push and pop on a non-full FIFO: both occur; count is unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH. A separate count register distinguishes full from empty.
- i_en=0: no push, no pop, no shift, no counter change; o_ready=0; o_valid holds its value.
- o_cin is held for all DATA_WIDTH bits of a word and updates only at load.

Optional Feature:
- Macro: OPERAND_FEEDER_STATS_EN.
- When defined:
  - Adds output ov_words_sent[15:0], reset 0.
  - Increments on each completed word (last-bit transfer) and wraps 0xFFFF→0.
  - Adds output o_overflow_seen, sticky, set when i_valid=1 & o_ready=0 & i_en=1; cleared only by reset.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package:
  - State encoding constants ST_IDLE and ST_SHIFT.
  - Counter-width function clog2 for the bit counter and FIFO pointers.
- Natural sub-module: operand_fifo, a synchronous FIFO of width 2*DATA_WIDTH+1 with push/pop/full/empty/count. The FSM and shifters stay in operand_feeder.

Test Plan:
- Single word, A=0x0003, B=0x0005, cin=1, i_ready=1 → o_valid rises 2 edges after accept. The A lane shows 1,1,0,… and the B lane shows 1,0,1,0,…, 16 bits in total; o_cin=1 throughout; then o_valid=0.
- Four words pushed back-to-back with i_ready=1 → 64 consecutive valid bits with no bubble. o_ready drops only if a fifth word is pushed while none has drained.
- Backpressure: i_ready toggles 1,0,0,1 during A=0xA5A5 → each bit is held while i_ready=0, and all 16 bits arrive in order.
- Full FIFO with i_ready=0: five words offered → four accepted, o_ready=0 for the fifth. With STATS_EN, o_overflow_seen=1.
- Reset asserted at bit 7 of a word with 2 words queued → after the reset edge o_valid=0 and the FIFO is empty. The next word starts from bit 0.
- i_en=0 for 3 cycles mid-word → outputs and bit index are frozen, and the stream resumes at the same bit once i_en=1.

Source files
------------

// File: rtl/operand_feeder_pkg.sv
// Shared types and helpers for the operand feeder: FSM state encoding and a
// width helper used for the bit counter and FIFO pointers.
package operand_feeder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Number of bits needed to index 'value' distinct items (ceil(log2(value))).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/operand_feeder_if.sv
// Word-side and serial-side handshake signals of the operand feeder.
// The feeder connects through the slave modport, the host/bench through master.
interface operand_feeder_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] iv_a;
  logic [DATA_WIDTH-1:0] iv_b;
  logic                  i_cin;
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_ready;
  logic                  o_din_a;
  logic                  o_din_b;
  logic                  o_cin;
  logic                  o_valid;

  modport slave (
    input  iv_a, iv_b, i_cin, i_valid, i_ready,
    output o_ready, o_din_a, o_din_b, o_cin, o_valid
  );

  modport master (
    output iv_a, iv_b, i_cin, i_valid, i_ready,
    input  o_ready, o_din_a, o_din_b, o_cin, o_valid
  );

endinterface

// File: rtl/operand_fifo.sv
// Synchronous FIFO holding packed {cin, B, A} operand words for the feeder.
// Pointers wrap naturally (DEPTH is a power of two); a count register tells full from empty.
module operand_fifo
  import operand_feeder_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [clog2(DEPTH+1)-1:0]  o_count
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) begin
      mem_d[wr_ptr_q] = i_wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (i_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until the count says it was written.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule

// File: rtl/operand_feeder.sv
// Accepts parallel A/B/cin words, buffers them and shifts them out LSB first on two
// serial lanes. Optional statistics ports are enabled with OPERAND_FEEDER_STATS_EN.
module operand_feeder
  import operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  operand_feeder_if.slave     bus
`ifdef OPERAND_FEEDER_STATS_EN
  ,
  output logic [15:0]         ov_words_sent,
  output logic                o_overflow_seen
`endif
);

  localparam int WW = 2 * DATA_WIDTH + 1;
  localparam int KW = (clog2(DATA_WIDTH) < 1) ? 1 : clog2(DATA_WIDTH);
  localparam int CW = clog2(FIFO_DEPTH + 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_a_q, sh_a_d;
  logic [DATA_WIDTH-1:0] sh_b_q, sh_b_d;
  logic                  cin_q, cin_d;
  logic [KW-1:0]         bit_cnt_q, bit_cnt_d;

  logic          ready;
  logic          push;
  logic          load;
  logic          xfer;
  logic          last_bit;
  logic [WW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign ready    = i_en & ~fifo_full & i_rst;
  assign push     = bus.i_valid & ready;
  assign xfer     = (state_q == ST_SHIFT) & bus.i_ready & i_en;
  assign last_bit = (bit_cnt_q == KW'(DATA_WIDTH - 1));

  operand_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (load),
    .i_wdata ({bus.i_cin, bus.iv_b, bus.iv_a}),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    cin_d     = cin_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_en && !fifo_empty) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (xfer) begin
          sh_a_d    = sh_a_q >> 1;
          sh_b_d    = sh_b_q >> 1;
          bit_cnt_d = bit_cnt_q + KW'(1);
          if (last_bit) begin
            bit_cnt_d = '0;
            if (fifo_count != '0) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A load overrides the shift so the next word starts without a bubble.
    if (load) begin
      sh_a_d    = fifo_rdata[DATA_WIDTH-1:0];
      sh_b_d    = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
      cin_d     = fifo_rdata[WW-1];
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      cin_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      cin_q     <= cin_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = (state_q == ST_SHIFT);
  assign bus.o_din_a = sh_a_q[0];
  assign bus.o_din_b = sh_b_q[0];
  assign bus.o_cin   = cin_q;

`ifdef OPERAND_FEEDER_STATS_EN
  logic [15:0] words_sent_q, words_sent_d;
  logic        overflow_seen_q, overflow_seen_d;

  always_comb begin
    words_sent_d    = words_sent_q + ((xfer && last_bit) ? 16'd1 : 16'd0);
    overflow_seen_d = overflow_seen_q | (bus.i_valid & ~ready & i_en);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      words_sent_q    <= '0;
      overflow_seen_q <= 1'b0;
    end else begin
      words_sent_q    <= words_sent_d;
      overflow_seen_q <= overflow_seen_d;
    end
  end

  assign ov_words_sent   = words_sent_q;
  assign o_overflow_seen = overflow_seen_q;
`endif

endmodule

// File: tb/tb_operand_feeder.sv
// Directed self-checking bench for operand_feeder: latency, streaming, backpressure,
// full FIFO, mid-word reset and enable freeze. Stats checks follow OPERAND_FEEDER_STATS_EN.
module tb_operand_feeder;

  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] wa [6];
  logic [DW-1:0] wb [6];
  logic          wc [6];

  operand_feeder_if #(.DATA_WIDTH(DW)) bus ();

`ifdef OPERAND_FEEDER_STATS_EN
  logic [15:0] words_sent;
  logic        overflow_seen;
`endif

  operand_feeder #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst_n),
    .i_en            (en),
    .bus             (bus)
`ifdef OPERAND_FEEDER_STATS_EN
    ,
    .ov_words_sent   (words_sent),
    .o_overflow_seen (overflow_seen)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic cin);
    bus.iv_a    = a;
    bus.iv_b    = b;
    bus.i_cin   = cin;
    bus.i_valid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expects a valid serial beat carrying bit k of the given word.
  task automatic checkBit(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic cin, input int k);
    checkOutput($sformatf("%s_valid[%0d]", tag, k), {31'd0, bus.o_valid}, 32'd1);
    checkOutput($sformatf("%s_a[%0d]", tag, k), {31'd0, bus.o_din_a}, {31'd0, a[k]});
    checkOutput($sformatf("%s_b[%0d]", tag, k), {31'd0, bus.o_din_b}, {31'd0, b[k]});
    checkOutput($sformatf("%s_cin[%0d]", tag, k), {31'd0, bus.o_cin}, {31'd0, cin});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int cyc;
    logic [3:0] rp;

    wa[0] = 16'h1234; wb[0] = 16'hFEDC; wc[0] = 1'b0;
    wa[1] = 16'hFFFF; wb[1] = 16'h0001; wc[1] = 1'b1;
    wa[2] = 16'h8000; wb[2] = 16'h7FFF; wc[2] = 1'b0;
    wa[3] = 16'hC3A5; wb[3] = 16'h5A3C; wc[3] = 1'b1;
    wa[4] = 16'h0F0F; wb[4] = 16'hF00F; wc[4] = 1'b1;
    wa[5] = 16'h6B2D; wb[5] = 16'h9001; wc[5] = 1'b1;

    bus.i_ready = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("rst_din_a", {31'd0, bus.o_din_a}, 32'd0);
    checkOutput("rst_din_b", {31'd0, bus.o_din_b}, 32'd0);
    checkOutput("rst_cin",   {31'd0, bus.o_cin},   32'd0);
    checkOutput("rst_ready", {31'd0, bus.o_ready}, 32'd0);
`ifdef OPERAND_FEEDER_STATS_EN
    checkOutput("rst_words", {16'd0, words_sent}, 32'd0);
    checkOutput("rst_ovf",   {31'd0, overflow_seen}, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready", {31'd0, bus.o_ready}, 32'd1);

    // Single word A=3, B=5, cin=1
    $display("[TB] single word");
    bus.i_ready = 1'b1;
    applyStimulus(1'b1, 16'h0003, 16'h0005, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("t1_lat", {31'd0, bus.o_valid}, 32'd0);
    tick();
    for (int k = 0; k < DW; k++) begin
      checkBit("t1", 16'h0003, 16'h0005, 1'b1, k);
      tick();
    end
    checkOutput("t1_done", {31'd0, bus.o_valid}, 32'd0);

    // Four words back-to-back, 64 beats with no bubble
    $display("[TB] four words back-to-back");
    for (int c = 0; c <= 66; c++) begin
      if (c < 4) begin
        applyStimulus(1'b1, wa[c], wb[c], wc[c]);
        checkOutput($sformatf("t2_ready%0d", c), {31'd0, bus.o_ready}, 32'd1);
      end else begin
        applyStimulus(1'b0, '0, '0, 1'b0);
      end
      if (c == 1) checkOutput("t2_lat", {31'd0, bus.o_valid}, 32'd0);
      if (c >= 2 && c <= 65) checkBit("t2", wa[(c-2)/16], wb[(c-2)/16], wc[(c-2)/16], (c-2)%16);
      if (c == 66) checkOutput("t2_done", {31'd0, bus.o_valid}, 32'd0);
      tick();
    end

    // Backpressure with i_ready pattern 1,0,0,1
    $display("[TB] backpressure");
    applyStimulus(1'b1, 16'hA5A5, 16'h5A5A, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick();
    rp  = 4'b1001;
    s   = 0;
    cyc = 0;
    while (s < DW && cyc < 100) begin
      bus.i_ready = rp[cyc[1:0]];
      checkBit("t3", 16'hA5A5, 16'h5A5A, 1'b0, s);
      tick();
      if (bus.i_ready) s++;
      cyc++;
    end
    checkOutput("t3_bits", s, DW);
    checkOutput("t3_done", {31'd0, bus.o_valid}, 32'd0);

    // Full FIFO: shifter holds one word, four more accepted, fifth refused
    $display("[TB] full fifo");
    bus.i_ready = 1'b0;
    applyStimulus(1'b1, wa[0], wb[0], wc[0]);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, wa[i+1], wb[i+1], wc[i+1]);
      checkOutput($sformatf("t4_ready%0d", i), {31'd0, bus.o_ready}, {31'd0, (i < 4)});
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
`ifdef OPERAND_FEEDER_STATS_EN
    checkOutput("t4_ovf", {31'd0, overflow_seen}, 32'd1);
`endif
    bus.i_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < DW; k++) begin
        checkBit($sformatf("t4w%0d", w), wa[w], wb[w], wc[w], k);
        tick();
      end
    end
    checkOutput("t4_done", {31'd0, bus.o_valid}, 32'd0);

    // Reset at bit 7 with two words queued
    $display("[TB] reset mid-word");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, wa[i], wb[i], wc[i]);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (6) tick();
    checkBit("t5_pre", wa[0], wb[0], wc[0], 7);
    rst_n = 1'b0;
    tick();
    checkOutput("t5_valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("t5_ready", {31'd0, bus.o_ready}, 32'd0);
    checkOutput("t5_din_a", {31'd0, bus.o_din_a}, 32'd0);
`ifdef OPERAND_FEEDER_STATS_EN
    checkOutput("t5_words", {16'd0, words_sent}, 32'd0);
    checkOutput("t5_ovf",   {31'd0, overflow_seen}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    checkOutput("t5_empty", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("t5_rel_ready", {31'd0, bus.o_ready}, 32'd1);
    applyStimulus(1'b1, wa[3], wb[3], wc[3]);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick();
    for (int k = 0; k < DW; k++) begin
      checkBit("t5", wa[3], wb[3], wc[3], k);
      tick();
    end
    checkOutput("t5_done", {31'd0, bus.o_valid}, 32'd0);

    // Enable low for three cycles at bit 5
    $display("[TB] enable freeze");
    applyStimulus(1'b1, wa[5], wb[5], wc[5]);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkBit("t6", wa[5], wb[5], wc[5], k);
      tick();
    end
    en = 1'b0;
    #1;
    checkOutput("t6_ready", {31'd0, bus.o_ready}, 32'd0);
    repeat (3) begin
      tick();
      checkBit("t6_frz", wa[5], wb[5], wc[5], 5);
    end
    en = 1'b1;
    for (int k = 5; k < DW; k++) begin
      checkBit("t6", wa[5], wb[5], wc[5], k);
      tick();
    end
    checkOutput("t6_done", {31'd0, bus.o_valid}, 32'd0);
`ifdef OPERAND_FEEDER_STATS_EN
    checkOutput("end_words", {16'd0, words_sent}, 32'd2);
    checkOutput("end_ovf",   {31'd0, overflow_seen}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
